// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory port.
// Accepts one access per req handshake, aligns address/byte-enables/store data,
// runs the memory req/gnt/rvalid protocol and returns lane-shifted, extended
// load data. Holds busy_o (pipeline stall) whenever it is not idle.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   req_valid_i/ready_o     access handshake (ready only while idle)
//   req_we_i, req_funct3_i  store flag and RV32I width/sign code
//   req_addr_i, req_wdata_i byte address and store data
//   rsp_valid_o             one-cycle completion pulse
//   rsp_err_o               00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
//   rsp_rdata_o             extended load data (0 for stores and errors)
//   busy_o                  access in flight
//   mem_req_o .. mem_wdata_o  request to memory, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory grant and read return
module lsu_mem_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [1:0]      rsp_err_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            busy_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              illegal;
  logic              misaligned;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata_lane;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;

  // Request checks use the incoming request so errors are decided at accept.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we_i;  // no unsigned stores
      default:                illegal = 1'b1;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3_i[1:0])
      2'b01:   misaligned = req_addr_i[0];
      2'b10:   misaligned = (req_addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data from the latched access.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata_q;
    if (we_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          be         = 4'b0001 << addr_q[1:0];
          wdata_lane = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be         = 4'b0011 << addr_q[1:0];
          wdata_lane = {2{wdata_q[15:0]}};
        end
        default: begin
          be         = 4'b1111;
          wdata_lane = wdata_q;
        end
      endcase
    end
  end

  // Move the addressed lane down to bit 0, then extend per funct3.
  always_comb begin
    shifted  = mem_rdata_i >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          rdata_d  = '0;
          err_d    = 2'b00;
          if (illegal) begin
            err_d   = 2'b10;
            state_d = StResp;
          end else if (misaligned) begin
            err_d   = 2'b01;
            state_d = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = we_q ? StResp : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid_i) begin
          // rvalid in the final counted cycle still wins over timeout
          rdata_d = load_ext;
          err_d   = 2'b00;
          cnt_d   = '0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          err_d   = 2'b11;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 2'b00;
    rsp_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      StReq: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
        mem_be_o    = be;
        mem_wdata_o = wdata_lane;
      end
      StWait: begin
        busy_o = 1'b1;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = rdata_q;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus randomized accesses, each checked
// against a reference model computed from width/sign/alignment rules.
module tb_lsu_mem_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .rsp_rdata_o  (rsp_rdata),
    .busy_o       (busy),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes is 1 << funct3[1:0].
  function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a);
    logic [31:0] sz;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 >= 3'd4)) return 2'b10;
    sz = 32'd1 << f3[1:0];
    if ((a % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] word);
    logic [31:0] w;
    logic [31:0] v;
    w = word >> (8 * a[1:0]);
    case (f3)
      3'd0: begin
        v = w & 32'hFF;
        return (v >= 32'd128) ? v - 32'd256 : v;
      end
      3'd4: return w & 32'hFF;
      3'd1: begin
        v = w & 32'hFFFF;
        return (v >= 32'd32768) ? v - 32'd65536 : v;
      end
      3'd5: return w & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a);
    logic [31:0] nbytes;
    logic [31:0] mask;
    if (!we) return 4'hF;
    nbytes = 32'd1 << f3[1:0];
    mask   = ((32'd1 << nbytes) - 32'd1) << a[1:0];
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] lo8;
    logic [31:0] lo16;
    lo8  = d & 32'hFF;
    lo16 = d & 32'hFFFF;
    case (f3[1:0])
      2'd0:    return lo8 * 32'h0101_0101;
      2'd1:    return lo16 * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // response, DUT idle again. gd: extra REQ cycles before gnt; rd: WAIT cycles
  // before rvalid (rd >= TO means rvalid is withheld).
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] word);
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    int          n;
    int          reqc;
    int          waitc;
    bit          done;
    bit          saw_req;
    e_err   = m_err(we, f3, addr);
    e_rdata = '0;
    if (e_err != 2'b00)  e_lat = 1;
    else if (we)         e_lat = gd + 2;
    else if (rd < int'(TO)) begin
      e_lat   = gd + 3 + rd;
      e_rdata = m_load(f3, addr, word);
    end else begin
      e_lat = gd + 2 + int'(TO);
      e_err = 2'b11;
    end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    // Scramble the request inputs: the DUT must work from its latched copy.
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    n = 1; reqc = 0; waitc = 0; done = 0; saw_req = 0;
    while (!done && n < 64) begin
      if (mem_req) begin
        saw_req = 1;
        reqc++;
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_be", {28'b0, mem_be}, {28'b0, m_be(we, f3, addr)});
        chk("mem_we", {31'b0, mem_we}, {31'b0, we});
        if (we) chk("mem_wdata", mem_wdata, m_wdata(f3, wd));
        mem_gnt    = (reqc == gd + 1);
        mem_rvalid = 1'($urandom);  // stray rvalid in REQ must be ignored
        mem_rdata  = $urandom;
      end else if (rsp_valid) begin
        chk("latency", n, e_lat);
        chk("rsp_err", {30'b0, rsp_err}, {30'b0, e_err});
        chk("rsp_rdata", rsp_rdata, e_rdata);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        done = 1;
      end else if (busy) begin
        waitc++;
        mem_gnt = 1'b0;
        if (waitc == rd + 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word;
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
        end
      end else begin
        vectors++;
        miscompares++;
        $error("FAIL idle_early: observed idle at cycle %0d expected response at %0d", n, e_lat);
        done = 1;
      end
      if (!done) begin
        @(negedge clk);
        n++;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL rsp_bound: observed no rsp_valid within %0d cycles expected at %0d", n, e_lat);
    end
    chk("mem_req_seen", {31'b0, saw_req}, {31'b0, (e_err == 2'b00 || e_err == 2'b11)});
    @(negedge clk);
    chk("ready_after", {31'b0, req_ready}, 32'd1);
    chk("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
    mem_rvalid = 1'($urandom);  // rvalid in IDLE must be ignored
    mem_rdata  = $urandom;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {30'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);  // lb
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h8001_0000);  // lhu
    do_access(1'b0, 3'b001, 32'h102, 32'h0, 1, 2, 32'h8001_0000);  // lh
    do_access(1'b1, 3'b000, 32'h201, 32'hAB, 3, 0, 32'h0);         // sb, slow gnt
    do_access(1'b1, 3'b001, 32'h302, 32'h1234_5678, 0, 0, 32'h0);  // sh upper half
    do_access(1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF, 2, 0, 32'h0);  // sw
    do_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h1111_1111);  // lw misaligned
    do_access(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h1111_1111);  // illegal funct3
    do_access(1'b1, 3'b101, 32'h101, 32'h0, 0, 0, 32'h0);          // illegal beats misalign
    do_access(1'b0, 3'b010, 32'h500, 32'h0, 0, TO - 1, 32'hCAFE_F00D);  // rvalid on last cycle
    do_access(1'b0, 3'b010, 32'h600, 32'h0, 0, 99, 32'h0);         // timeout
    mem_rvalid = 1'b1;  // late rvalid after timeout
    mem_rdata  = 32'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("late_rvalid_ready", {31'b0, req_ready}, 32'd1);

    // Reset while waiting for read data aborts the access
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wait_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    do_access(1'b0, 3'b100, 32'h41, 32'h0, 0, 0, 32'h0000_9A00);   // lbu after abort

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          rd;
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      rd   = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 4));
      do_access(we, f3, addr, $urandom, int'($urandom_range(0, 3)), rd, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
